cpu_run_sequencer: RTL and testbench
====================================

# cpu_run_sequencer

Bring-up and run controller for `CPU_TopLevel`. It drives `sync_rst`, `clk_en` and `SystemEn` in a fixed power-on order, then runs the core until one of three events occurs: the core halts, a programmable cycle budget is spent, or the run is aborted. After a halt or budget stop it keeps the core clocked for a fixed drain window with `SystemEn` low, then reports completion. It sits between the top-level/system glue (or a bench) and the CPU, and replaces ad-hoc count-compare enable generation.

## Interface
Parameters:
- `RST_CYCLES`, default 2: cycles `cpu_sync_rst` is held high; must be ≥1.
- `WARMUP_CYCLES`, default 3: cycles with `cpu_clk_en`=1 and `cpu_system_en`=0 before the run; must be ≥1.
- `DRAIN_CYCLES`, default 8: clocked cycles after a halt or limit stop; must be ≥1.
- `CYCLE_BW`, default 32: width of the cycle budget and run counter.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: begin a sequence; sampled only in IDLE or DONE.
- `abort`, in, 1: terminate immediately from any busy state.
- `cycle_limit`, in, CYCLE_BW: RUN-cycle budget, latched on accepted `start`; 0 means unlimited.
- `halt_in`, in, 1: CPU halt indication; sampled only in RUN.
- `cpu_sync_rst`, out, 1: to CPU `sync_rst`.
- `cpu_clk_en`, out, 1: to CPU `clk_en`.
- `cpu_system_en`, out, 1: to CPU `SystemEn`.
- `busy`, out, 1: high in RST, WARM, RUN and DRAIN.
- `done`, out, 1: high in DONE.
- `done_cause`, out, 2: 0 = none, 1 = halt, 2 = limit, 3 = abort.
- `run_cycles`, out, CYCLE_BW: number of cycles spent in RUN in the current or last sequence.

## Operation
- Moore FSM with registered outputs. States: IDLE, RST, WARM, RUN, DRAIN, DONE. A single down-counter, sized `$clog2(max(param)+1)`, times RST, WARM and DRAIN.
- Outputs per state (sync_rst / clk_en / system_en / busy / done):
  - IDLE: 0/0/0/0/0
  - RST: 1/0/0/1/0
  - WARM: 0/1/0/1/0
  - RUN: 0/1/1/1/0
  - DRAIN: 0/1/0/1/0
  - DONE: 0/0/0/0/1
- IDLE or DONE, `start`=1 → RST:
  - latch `cycle_limit`;
  - clear `run_cycles` and `done_cause`;
  - load the counter with `RST_CYCLES`.
- RST → WARM after `RST_CYCLES` cycles. WARM → RUN after `WARMUP_CYCLES` cycles.
- RUN: `run_cycles` increments every cycle. It saturates at all-ones, and can only reach saturation when the limit is 0.
- RUN exit on halt: `halt_in`=1 → DRAIN, cause 1.
- RUN exit on limit: latched limit ≠ 0 and `run_cycles`+1 == limit → DRAIN, cause 2. This gives exactly `limit` cycles with `cpu_system_en`=1.
- Halt and limit in the same cycle: halt wins (cause 1); `run_cycles` still counts that cycle.
- DRAIN → DONE after `DRAIN_CYCLES` cycles.
- `abort`=1 in RST, WARM, RUN or DRAIN → DONE next cycle with cause 3. Abort has priority over every other transition, and no drain runs. If abort lands in RUN, the RUN cycle in which it is sampled is counted.
- `abort` in IDLE or DONE: ignored.
- `start` while busy: ignored.
- DONE holds `done_cause` and `run_cycles` until the next accepted `start`.
- `rst` asserted: state IDLE, all outputs 0, `run_cycles`=0, latched limit 0. This holds asynchronously, including mid-run.

## Timing
- Accepted `start` sampled at edge 0. Cycles below are the intervals after edge N.
  - Cycles 1..RST_CYCLES: RST.
  - Next WARMUP_CYCLES cycles: WARM.
  - Then RUN.
- Default parameters: `cpu_sync_rst` high in cycles 1–2; `cpu_clk_en` rises at cycle 3; `cpu_system_en` rises at cycle 6.
- Exit latency:
  - `halt_in` sampled high at edge N → `cpu_system_en` low from cycle N+1, DRAIN for DRAIN_CYCLES cycles, `done` high after that.
  - `abort` sampled at edge N → `done`=1 and all CPU controls 0 in cycle N+1.
- No combinational path from any input to any output.

## Test plan
- Reset: `rst` pulse during RUN → all outputs 0 immediately, without waiting for a clock edge; `start` after release sequences from RST.
- Limit stop, defaults, `cycle_limit`=5, `start` at edge 0 → RST in cycles 1–2, WARM in 3–5, `cpu_system_en` in 6–10, DRAIN in 11–18, `done`=1 from cycle 19, `done_cause`=2, `run_cycles`=5.
- Halt stop, `cycle_limit`=0, `halt_in` high during the 4th RUN cycle → `cpu_system_en` low the next cycle, 8 drain cycles, then `done_cause`=1, `run_cycles`=4.
- `cycle_limit`=3 with `halt_in` high in the 3rd RUN cycle → `done_cause`=1, `run_cycles`=3.
- `abort` during cycle 4 (WARM) → cycle 5 is DONE, `done_cause`=3, `run_cycles`=0, no drain.
- `start` pulsed during RUN → ignored, `run_cycles` continues. `start` in DONE → `done` drops, new sequence, `run_cycles` cleared.

Source files
------------

// File: rtl/cpu_run_sequencer.sv
// Power-on and run sequencer for CPU_TopLevel: orders sync reset, clock enable and
// system enable, runs the core until halt, cycle budget or abort, then drains and reports.
module cpu_run_sequencer #(
    parameter int RST_CYCLES    = 2,
    parameter int WARMUP_CYCLES = 3,
    parameter int DRAIN_CYCLES  = 8,
    parameter int CYCLE_BW      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [CYCLE_BW-1:0] cycle_limit,
    input  logic                halt_in,
    output logic                cpu_sync_rst,
    output logic                cpu_clk_en,
    output logic                cpu_system_en,
    output logic                busy,
    output logic                done,
    output logic [1:0]          done_cause,
    output logic [CYCLE_BW-1:0] run_cycles
);

    localparam int MAX_RW  = (RST_CYCLES > WARMUP_CYCLES) ? RST_CYCLES : WARMUP_CYCLES;
    localparam int CNT_MAX = (MAX_RW > DRAIN_CYCLES) ? MAX_RW : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] WARM_LOAD  = CNT_W'(WARMUP_CYCLES);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_RST, S_WARM, S_RUN, S_DRAIN, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_HALT  = 2'd1,
        CAUSE_LIMIT = 2'd2,
        CAUSE_ABORT = 2'd3
    } cause_t;

    typedef struct packed {
        logic sync_rst;
        logic clk_en;
        logic system_en;
        logic busy;
        logic done;
    } ctrl_t;

    state_t              state_q, state_d;
    cause_t              cause_q, cause_d;
    ctrl_t               ctrl_q, ctrl_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CYCLE_BW-1:0] run_q, run_d;
    logic [CYCLE_BW-1:0] limit_q, limit_d;
    logic [CYCLE_BW-1:0] run_inc;
    logic                cnt_last;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        limit_d  = limit_q;
        run_inc  = (run_q == '1) ? run_q : run_q + CYCLE_BW'(1);
        cnt_last = (cnt_q == CNT_W'(1));

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RST;
                    limit_d = cycle_limit;
                    run_d   = '0;
                    cause_d = CAUSE_NONE;
                    cnt_d   = RST_LOAD;
                end
            end
            S_RST: begin
                if (abort) begin
                    state_d = S_DONE;
                    cause_d = CAUSE_ABORT;
                end else if (cnt_last) begin
                    state_d = S_WARM;
                    cnt_d   = WARM_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WARM: begin
                if (abort) begin
                    state_d = S_DONE;
                    cause_d = CAUSE_ABORT;
                end else if (cnt_last) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RUN: begin
                // The sampled RUN cycle is counted whichever way the run ends.
                run_d = run_inc;
                if (abort) begin
                    state_d = S_DONE;
                    cause_d = CAUSE_ABORT;
                end else if (halt_in) begin
                    state_d = S_DRAIN;
                    cause_d = CAUSE_HALT;
                    cnt_d   = DRAIN_LOAD;
                end else if (limit_q != '0 && run_inc == limit_q) begin
                    state_d = S_DRAIN;
                    cause_d = CAUSE_LIMIT;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_DONE;
                    cause_d = CAUSE_ABORT;
                end else if (cnt_last) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered with it.
        ctrl_d = '0;
        case (state_d)
            S_RST:   ctrl_d = '{sync_rst: 1'b1, clk_en: 1'b0, system_en: 1'b0, busy: 1'b1, done: 1'b0};
            S_WARM:  ctrl_d = '{sync_rst: 1'b0, clk_en: 1'b1, system_en: 1'b0, busy: 1'b1, done: 1'b0};
            S_RUN:   ctrl_d = '{sync_rst: 1'b0, clk_en: 1'b1, system_en: 1'b1, busy: 1'b1, done: 1'b0};
            S_DRAIN: ctrl_d = '{sync_rst: 1'b0, clk_en: 1'b1, system_en: 1'b0, busy: 1'b1, done: 1'b0};
            S_DONE:  ctrl_d = '{sync_rst: 1'b0, clk_en: 1'b0, system_en: 1'b0, busy: 1'b0, done: 1'b1};
            default: ctrl_d = '0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cause_q <= CAUSE_NONE;
            ctrl_q  <= '0;
            cnt_q   <= '0;
            run_q   <= '0;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            limit_q <= limit_d;
        end
    end

    assign cpu_sync_rst  = ctrl_q.sync_rst;
    assign cpu_clk_en    = ctrl_q.clk_en;
    assign cpu_system_en = ctrl_q.system_en;
    assign busy          = ctrl_q.busy;
    assign done          = ctrl_q.done;
    assign done_cause    = cause_q;
    assign run_cycles    = run_q;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed bench for cpu_run_sequencer with default parameters; expected values are
// hand-derived cycle by cycle from the start edge.
module tb_cpu_run_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] cycle_limit;
    logic        halt_in;
    logic        cpu_sync_rst;
    logic        cpu_clk_en;
    logic        cpu_system_en;
    logic        busy;
    logic        done;
    logic [1:0]  done_cause;
    logic [31:0] run_cycles;
    logic [4:0]  ctrl;

    int vectors     = 0;
    int miscompares = 0;

    cpu_run_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .cycle_limit   (cycle_limit),
        .halt_in       (halt_in),
        .cpu_sync_rst  (cpu_sync_rst),
        .cpu_clk_en    (cpu_clk_en),
        .cpu_system_en (cpu_system_en),
        .busy          (busy),
        .done          (done),
        .done_cause    (done_cause),
        .run_cycles    (run_cycles)
    );

    // {sync_rst, clk_en, system_en, busy, done}
    assign ctrl = {cpu_sync_rst, cpu_clk_en, cpu_system_en, busy, done};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called from IDLE/DONE; returns in cycle 1 (first RST cycle).
    task automatic do_start(input logic [31:0] limit);
        cycle_limit = limit;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; halt_in = 1'b0; cycle_limit = '0;
        #3;
        vectors++;
        if (ctrl !== 5'b00000 || run_cycles !== 32'd0 || done_cause !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_state: ctrl=%b run=%0d cause=%0d, expected ctrl=00000 run=0 cause=0",
                     ctrl, run_cycles, done_cause);
        end
        step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        vectors++;
        if (ctrl !== 5'b00000) begin
            miscompares++;
            $display("FAIL start_in_reset: ctrl=%b expected 00000", ctrl);
        end
        rst = 1'b0;
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        vectors++;
        if (ctrl !== 5'b00000 || done_cause !== 2'd0) begin
            miscompares++;
            $display("FAIL abort_in_idle: ctrl=%b cause=%0d expected ctrl=00000 cause=0", ctrl, done_cause);
        end
    endtask

    task automatic test_limit_stop();
        logic [4:0] exp;
        do_start(32'd5);
        for (int c = 1; c <= 19; c++) begin
            exp = (c <= 2)  ? 5'b10010 :
                  (c <= 5)  ? 5'b01010 :
                  (c <= 10) ? 5'b01110 :
                  (c <= 18) ? 5'b01010 : 5'b00001;
            vectors++;
            if (ctrl !== exp) begin
                miscompares++;
                $display("FAIL limit_seq cycle %0d: ctrl=%b expected %b", c, ctrl, exp);
            end
            if (c < 19) step(1);
        end
        vectors++;
        if (done_cause !== 2'd2 || run_cycles !== 32'd5) begin
            miscompares++;
            $display("FAIL limit_result: cause=%0d run=%0d expected cause=2 run=5", done_cause, run_cycles);
        end
    endtask

    task automatic test_halt_stop();
        do_start(32'd0);
        step(8);                       // cycle 9 = 4th RUN cycle
        halt_in = 1'b1;
        vectors++;
        if (ctrl !== 5'b01110 || run_cycles !== 32'd3) begin
            miscompares++;
            $display("FAIL halt_run4: ctrl=%b run=%0d expected ctrl=01110 run=3", ctrl, run_cycles);
        end
        step(1);                       // cycle 10, first DRAIN cycle
        halt_in = 1'b0;
        vectors++;
        if (ctrl !== 5'b01010 || run_cycles !== 32'd4) begin
            miscompares++;
            $display("FAIL halt_drain_entry: ctrl=%b run=%0d expected ctrl=01010 run=4", ctrl, run_cycles);
        end
        step(7);                       // cycle 17, last DRAIN cycle
        vectors++;
        if (ctrl !== 5'b01010) begin
            miscompares++;
            $display("FAIL halt_drain_last: ctrl=%b expected 01010", ctrl);
        end
        step(1);                       // cycle 18
        vectors++;
        if (ctrl !== 5'b00001 || done_cause !== 2'd1 || run_cycles !== 32'd4) begin
            miscompares++;
            $display("FAIL halt_done: ctrl=%b cause=%0d run=%0d expected ctrl=00001 cause=1 run=4",
                     ctrl, done_cause, run_cycles);
        end
    endtask

    task automatic test_halt_limit_tie();
        do_start(32'd3);
        step(7);                       // cycle 8 = 3rd RUN cycle
        halt_in = 1'b1;
        step(1);
        halt_in = 1'b0;
        vectors++;
        if (ctrl !== 5'b01010 || run_cycles !== 32'd3) begin
            miscompares++;
            $display("FAIL tie_drain: ctrl=%b run=%0d expected ctrl=01010 run=3", ctrl, run_cycles);
        end
        step(7);                       // cycle 16, last DRAIN cycle
        vectors++;
        if (ctrl !== 5'b01010) begin
            miscompares++;
            $display("FAIL tie_drain_last: ctrl=%b expected 01010", ctrl);
        end
        step(1);
        vectors++;
        if (ctrl !== 5'b00001 || done_cause !== 2'd1 || run_cycles !== 32'd3) begin
            miscompares++;
            $display("FAIL tie_done: ctrl=%b cause=%0d run=%0d expected ctrl=00001 cause=1 run=3",
                     ctrl, done_cause, run_cycles);
        end
    endtask

    task automatic test_abort_warm();
        do_start(32'd0);
        step(3);                       // cycle 4, WARM
        abort = 1'b1;
        vectors++;
        if (ctrl !== 5'b01010) begin
            miscompares++;
            $display("FAIL abort_warm_pre: ctrl=%b expected 01010", ctrl);
        end
        step(1);                       // cycle 5
        abort = 1'b0;
        vectors++;
        if (ctrl !== 5'b00001 || done_cause !== 2'd3 || run_cycles !== 32'd0) begin
            miscompares++;
            $display("FAIL abort_warm_done: ctrl=%b cause=%0d run=%0d expected ctrl=00001 cause=3 run=0",
                     ctrl, done_cause, run_cycles);
        end
        step(2);
        vectors++;
        if (ctrl !== 5'b00001 || done_cause !== 2'd3) begin
            miscompares++;
            $display("FAIL abort_warm_hold: ctrl=%b cause=%0d expected ctrl=00001 cause=3", ctrl, done_cause);
        end
    endtask

    task automatic test_back_to_back();
        do_start(32'd0);
        step(6);                       // cycle 7, 2nd RUN cycle
        start = 1'b1;
        step(1);                       // cycle 8
        start = 1'b0;
        vectors++;
        if (ctrl !== 5'b01110 || run_cycles !== 32'd2) begin
            miscompares++;
            $display("FAIL start_in_run: ctrl=%b run=%0d expected ctrl=01110 run=2", ctrl, run_cycles);
        end
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        vectors++;
        if (ctrl !== 5'b00001 || done_cause !== 2'd3 || run_cycles !== 32'd3) begin
            miscompares++;
            $display("FAIL abort_run: ctrl=%b cause=%0d run=%0d expected ctrl=00001 cause=3 run=3",
                     ctrl, done_cause, run_cycles);
        end
        do_start(32'd7);               // restart from DONE
        vectors++;
        if (ctrl !== 5'b10010 || done_cause !== 2'd0 || run_cycles !== 32'd0) begin
            miscompares++;
            $display("FAIL restart: ctrl=%b cause=%0d run=%0d expected ctrl=10010 cause=0 run=0",
                     ctrl, done_cause, run_cycles);
        end
        step(11);                      // cycle 12, last RUN cycle
        vectors++;
        if (ctrl !== 5'b01110) begin
            miscompares++;
            $display("FAIL restart_run_last: ctrl=%b expected 01110", ctrl);
        end
        step(9);                       // cycle 21
        vectors++;
        if (ctrl !== 5'b00001 || done_cause !== 2'd2 || run_cycles !== 32'd7) begin
            miscompares++;
            $display("FAIL restart_done: ctrl=%b cause=%0d run=%0d expected ctrl=00001 cause=2 run=7",
                     ctrl, done_cause, run_cycles);
        end
    endtask

    task automatic test_async_reset();
        do_start(32'd0);
        step(7);                       // cycle 8, RUN
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (ctrl !== 5'b00000 || run_cycles !== 32'd0 || done_cause !== 2'd0) begin
            miscompares++;
            $display("FAIL async_reset: ctrl=%b run=%0d cause=%0d expected ctrl=00000 run=0 cause=0",
                     ctrl, run_cycles, done_cause);
        end
        step(2);
        rst = 1'b0;
        do_start(32'd0);
        vectors++;
        if (ctrl !== 5'b10010) begin
            miscompares++;
            $display("FAIL post_reset_rst: ctrl=%b expected 10010", ctrl);
        end
        step(2);                       // cycle 3, WARM
        vectors++;
        if (ctrl !== 5'b01010) begin
            miscompares++;
            $display("FAIL post_reset_warm: ctrl=%b expected 01010", ctrl);
        end
        step(3);                       // cycle 6, RUN
        vectors++;
        if (ctrl !== 5'b01110 || run_cycles !== 32'd0) begin
            miscompares++;
            $display("FAIL post_reset_run: ctrl=%b run=%0d expected ctrl=01110 run=0", ctrl, run_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_limit_stop();
        test_halt_stop();
        test_halt_limit_tie();
        test_abort_warm();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
